ysyx_25040129_hazard_ctrl: RTL and testbench

- Scoreboard-based issue controller between the decode stage and the execute stage of the multi-cycle RV32 core.
- Tracks outstanding register writes per architectural register and gates the decode→execute valid/ready handshake on RAW/WAW hazards.
- Serialises CSR writes.
- Provides a drain sequence that empties the pipeline for ecall/mret/fence-style events.

---
 rtl/ysyx_25040129_hazard_ctrl_pkg.sv | 32 +++
 rtl/ysyx_25040129_sb_cnt.sv | 29 ++
 rtl/ysyx_25040129_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_25040129_hazard_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_hazard_ctrl_pkg.sv
// Shared definitions for the decode->execute hazard controller: FSM encodings,
// the x0 index constant, the tracked-register default and the decode request bundle.
package ysyx_25040129_hazard_ctrl_pkg;

    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned IDX_W    = 5;

    localparam logic [IDX_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } hc_state_e;

    // Register-usage view of the instruction waiting in decode
    typedef struct packed {
        logic [IDX_W-1:0] rs1_id;
        logic [IDX_W-1:0] rs2_id;
        logic [IDX_W-1:0] rd_id;
        logic             rs1_used;
        logic             rs2_used;
        logic             reg_write;
        logic             csr_write;
    } issue_req_t;

    // x0 is hardwired to zero, so it never carries a dependency
    function automatic logic idx_live(input logic [IDX_W-1:0] idx);
        return idx != REG_X0;
    endfunction

endpackage

// File: rtl/ysyx_25040129_sb_cnt.sv
// Per-register in-flight write counter: saturating up/down with an underflow flag.
// Simultaneous inc and dec leave the count unchanged.
module ysyx_25040129_sb_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             udf_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A retire against an empty counter is a bookkeeping error upstream
    assign udf_c = dec && !inc && (cnt == '0);

endmodule

// File: rtl/ysyx_25040129_hazard_ctrl.sv
// Scoreboard issue controller between decode and execute: RAW/WAW/CSR gating and drain FSM.
// Optional stall statistic enabled by defining YSYX_25040129_HAZARD_STAT_EN.
module ysyx_25040129_hazard_ctrl
    import ysyx_25040129_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned INFL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idu_valid_in,
    output logic              idu_ready_out,
    output logic              exu_valid_out,
    input  logic              exu_ready_in,
    input  logic [IDX_W-1:0]  rs1_id,
    input  logic [IDX_W-1:0]  rs2_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [IDX_W-1:0]  rd_id,
    input  logic              reg_write_in,
    input  logic              csr_write_in,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic              wb_reg_write,
    input  logic              wb_csr_write,
    input  logic              drain_req,
    output logic              drain_done,
    output logic              hazard,
    output logic [INFL_W-1:0] inflight,
    output logic              sb_err,
    output logic [31:0]       stall_cycles
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [INFL_W-1:0] INFL_MAX = {INFL_W{1'b1}};

    issue_req_t        req;
    hc_state_e         state;
    hc_state_e         state_nxt;
    logic              blk_state;
    logic              blk;
    logic              issue;
    logic              inc;
    logic              dec;
    logic              dec_ok;
    logic              raw1;
    logic              raw2;
    logic              waw_full;
    logic              tot_full;
    logic              csr_pending;
    logic              sb_err_q;
    logic [INFL_W-1:0] inflight_q;

    logic [CNT_W-1:0]  cnt [NREG];
    logic [NREG-1:1]   inc_vec;
    logic [NREG-1:1]   dec_vec;
    logic [NREG-1:1]   udf_vec;

    assign req = '{rs1_id:    rs1_id,
                   rs2_id:    rs2_id,
                   rd_id:     rd_id,
                   rs1_used:  rs1_used,
                   rs2_used:  rs2_used,
                   reg_write: reg_write_in,
                   csr_write: csr_write_in};

    // Hazard looks only at registered state; a retiring write unblocks one cycle later
    assign raw1     = req.rs1_used && idx_live(req.rs1_id) && (cnt[req.rs1_id] != '0);
    assign raw2     = req.rs2_used && idx_live(req.rs2_id) && (cnt[req.rs2_id] != '0);
    assign waw_full = req.reg_write && idx_live(req.rd_id) && (cnt[req.rd_id] == CNT_MAX);
    assign tot_full = req.reg_write && idx_live(req.rd_id) && (inflight_q == INFL_MAX);
    assign hazard   = raw1 || raw2 || waw_full || tot_full || csr_pending;

    assign blk           = hazard || blk_state;
    assign exu_valid_out = idu_valid_in && !blk;
    assign idu_ready_out = exu_ready_in && !blk;
    assign issue         = idu_valid_in && exu_ready_in && !blk;

    assign inc = issue && req.reg_write && idx_live(req.rd_id);
    assign dec = wb_valid && wb_reg_write && idx_live(wb_rd);

    // A retire only reduces the total if its register counter actually held a write
    assign dec_ok = dec && ((cnt[wb_rd] != '0) || (inc && (req.rd_id == wb_rd)));

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            inc_vec[i] = inc && (req.rd_id == IDX_W'(i));
            dec_vec[i] = dec && (wb_rd == IDX_W'(i));
        end
    end

    assign cnt[0] = '0;

    generate
        for (genvar g = 1; g < NREG; g++) begin : g_cnt
            ysyx_25040129_sb_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc_vec[g]),
                .dec   (dec_vec[g]),
                .cnt   (cnt[g]),
                .udf_c (udf_vec[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else if (inc && !dec_ok) begin
            inflight_q <= inflight_q + INFL_W'(1);
        end else if (!inc && dec_ok) begin
            inflight_q <= inflight_q - INFL_W'(1);
        end
    end

    assign inflight = inflight_q;

    // CSR retire wins over a new CSR issue in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_pending <= 1'b0;
        end else if (wb_valid && wb_csr_write) begin
            csr_pending <= 1'b0;
        end else if (issue && req.csr_write) begin
            csr_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_q <= 1'b0;
        end else if (|udf_vec) begin
            sb_err_q <= 1'b1;
        end
    end

    assign sb_err = sb_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:   state_nxt = drain_req ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt = ((inflight_q == '0) && !csr_pending) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Issue is blocked everywhere except RUN; an illegal code blocks until it recovers
    always_comb begin
        blk_state  = 1'b1;
        drain_done = 1'b0;
        case (state)
            ST_RUN:   blk_state  = 1'b0;
            ST_DRAIN: blk_state  = 1'b1;
            ST_DONE:  drain_done = 1'b1;
            default:  blk_state  = 1'b1;
        endcase
    end

`ifdef YSYX_25040129_HAZARD_STAT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (idu_valid_in && blk) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ysyx_25040129_hazard_ctrl.sv
// Self-checking bench for ysyx_25040129_hazard_ctrl: per-scenario tasks push expected
// output snapshots into a scoreboard queue and pop/compare them as the DUT settles.
module tb_ysyx_25040129_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        idu_valid_in;
    logic        idu_ready_out;
    logic        exu_valid_out;
    logic        exu_ready_in;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rd_id;
    logic        reg_write_in;
    logic        csr_write_in;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_csr_write;
    logic        drain_req;
    logic        drain_done;
    logic        hazard;
    logic [3:0]  inflight;
    logic        sb_err;
    logic [31:0] stall_cycles;

    typedef struct packed {
        logic       hz;
        logic       ev;
        logic       ir;
        logic       dd;
        logic       err;
        logic [3:0] infl;
    } obs_t;

    obs_t exp_q [$];
    int   n_vec = 0;
    int   n_bad = 0;

    ysyx_25040129_hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .idu_valid_in  (idu_valid_in),
        .idu_ready_out (idu_ready_out),
        .exu_valid_out (exu_valid_out),
        .exu_ready_in  (exu_ready_in),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .rd_id         (rd_id),
        .reg_write_in  (reg_write_in),
        .csr_write_in  (csr_write_in),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_csr_write  (wb_csr_write),
        .drain_req     (drain_req),
        .drain_done    (drain_done),
        .hazard        (hazard),
        .inflight      (inflight),
        .sb_err        (sb_err),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int hz, input int ev, input int ir,
                                input int dd, input int err, input int infl);
        obs_t o;
        o.hz   = 1'(hz);
        o.ev   = 1'(ev);
        o.ir   = 1'(ir);
        o.dd   = 1'(dd);
        o.err  = 1'(err);
        o.infl = 4'(infl);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.hz   = hazard;
        o.ev   = exu_valid_out;
        o.ir   = idu_ready_out;
        o.dd   = drain_done;
        o.err  = sb_err;
        o.infl = inflight;
        return o;
    endfunction

    task automatic inst(input int v, input int r1, input int u1, input int r2,
                        input int u2, input int rd, input int rw, input int cw);
        idu_valid_in = 1'(v);
        rs1_id       = 5'(r1);
        rs1_used     = 1'(u1);
        rs2_id       = 5'(r2);
        rs2_used     = 1'(u2);
        rd_id        = 5'(rd);
        reg_write_in = 1'(rw);
        csr_write_in = 1'(cw);
    endtask

    task automatic wbk(input int v, input int rd, input int rw, input int cw);
        wb_valid     = 1'(v);
        wb_rd        = 5'(rd);
        wb_reg_write = 1'(rw);
        wb_csr_write = 1'(cw);
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            case (k)
                0: begin inst(0,0,0,0,0,0,0,0); wbk(0,0,0,0); exp_q.push_back(mk(0,0,1,0,0,0)); end
                1: begin inst(1,0,0,0,0,3,1,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                2: begin rst = 1'b0; inst(0,0,0,0,0,0,0,0); exp_q.push_back(mk(0,0,1,0,0,0)); end
                default: exp_q.push_back(mk(0,0,1,0,0,0));
            endcase
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_raw();
        obs_t o, e;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            case (k)
                0: begin inst(1,0,1,0,0,5,1,0); wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                1: begin inst(1,5,1,1,1,6,1,0); exp_q.push_back(mk(1,0,0,0,0,1)); end
                2: begin wbk(1,5,1,0); exp_q.push_back(mk(1,0,0,0,0,1)); end
                3: begin wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                4: begin inst(0,0,0,0,0,0,0,0); wbk(1,6,1,0); exp_q.push_back(mk(0,0,1,0,0,1)); end
                default: begin wbk(0,0,0,0); exp_q.push_back(mk(0,0,1,0,0,0)); end
            endcase
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL raw step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_waw();
        obs_t o, e;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 3) begin
                inst(1,0,0,0,0,7,1,0); wbk(0,0,0,0);
                exp_q.push_back(mk(0,1,1,0,0,k));
            end else if (k == 3) begin
                exp_q.push_back(mk(1,0,0,0,0,3));
            end else if (k == 4) begin
                wbk(1,7,1,0);
                exp_q.push_back(mk(1,0,0,0,0,3));
            end else if (k == 5) begin
                wbk(0,0,0,0);
                exp_q.push_back(mk(0,1,1,0,0,2));
            end else if (k < 9) begin
                inst(0,0,0,0,0,0,0,0); wbk(1,7,1,0);
                exp_q.push_back(mk(0,0,1,0,0,3 - (k - 6)));
            end else begin
                wbk(0,0,0,0);
                exp_q.push_back(mk(0,0,1,0,0,0));
            end
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL waw step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_x0();
        obs_t o, e;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            case (k)
                0: begin inst(1,0,0,0,0,0,1,0); wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                1: begin inst(1,0,1,0,1,9,0,0); wbk(1,0,1,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                2: begin inst(1,0,0,0,0,20,1,0); wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                3: begin inst(1,3,1,20,1,21,1,0); exp_q.push_back(mk(1,0,0,0,0,1)); end
                4: begin inst(1,3,1,20,0,21,1,0); exp_q.push_back(mk(0,1,1,0,0,1)); end
                5: begin inst(0,0,0,0,0,0,0,0); wbk(1,20,1,0); exp_q.push_back(mk(0,0,1,0,0,2)); end
                6: begin wbk(1,21,1,0); exp_q.push_back(mk(0,0,1,0,0,1)); end
                7: begin exu_ready_in = 1'b0; inst(1,0,0,0,0,22,1,0); wbk(0,0,0,0);
                          exp_q.push_back(mk(0,1,0,0,0,0)); end
                default: begin exu_ready_in = 1'b1; inst(0,0,0,0,0,0,0,0);
                               exp_q.push_back(mk(0,0,1,0,0,0)); end
            endcase
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL x0 step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_full();
        obs_t o, e;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (k < 15) begin
                inst(1,0,0,0,0,k + 1,1,0); wbk(0,0,0,0);
                exp_q.push_back(mk(0,1,1,0,0,k));
            end else if (k == 15) begin
                inst(1,0,0,0,0,16,1,0);
                exp_q.push_back(mk(1,0,0,0,0,15));
            end else if (k == 16) begin
                inst(1,0,0,0,0,16,0,0);
                exp_q.push_back(mk(0,1,1,0,0,15));
            end else if (k == 17) begin
                inst(1,0,0,0,0,0,1,0);
                exp_q.push_back(mk(0,1,1,0,0,15));
            end else if (k < 33) begin
                inst(0,0,0,0,0,0,0,0); wbk(1,k - 17,1,0);
                exp_q.push_back(mk(0,0,1,0,0,15 - (k - 18)));
            end else begin
                wbk(0,0,0,0);
                exp_q.push_back(mk(0,0,1,0,0,0));
            end
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL full step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_csr();
        obs_t o, e;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            case (k)
                0: begin inst(1,0,0,0,0,0,0,1); wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                1: begin exp_q.push_back(mk(1,0,0,0,0,0)); end
                2: begin inst(1,0,0,0,0,4,1,0); exp_q.push_back(mk(1,0,0,0,0,0)); end
                3: begin inst(1,0,0,0,0,0,0,1); wbk(1,0,0,1); exp_q.push_back(mk(1,0,0,0,0,0)); end
                4: begin wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                5: begin inst(0,0,0,0,0,0,0,0); wbk(1,0,0,1); exp_q.push_back(mk(1,0,0,0,0,0)); end
                6: begin inst(1,0,0,0,0,0,0,1); wbk(1,0,0,1); exp_q.push_back(mk(0,1,1,0,0,0)); end
                7: begin inst(1,0,0,0,0,0,0,0); wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                default: begin inst(0,0,0,0,0,0,0,0); exp_q.push_back(mk(0,0,1,0,0,0)); end
            endcase
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL csr step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_drain();
        obs_t o, e;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            case (k)
                0: begin inst(1,0,0,0,0,11,1,0); wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                1: begin inst(1,0,0,0,0,12,1,0); exp_q.push_back(mk(0,1,1,0,0,1)); end
                2: begin inst(0,0,0,0,0,0,0,0); drain_req = 1'b1; exp_q.push_back(mk(0,0,1,0,0,2)); end
                3: begin drain_req = 1'b0; inst(1,0,0,0,0,13,1,0); wbk(1,11,1,0);
                          exp_q.push_back(mk(0,0,0,0,0,2)); end
                4: begin wbk(1,12,1,0); exp_q.push_back(mk(0,0,0,0,0,1)); end
                5: begin wbk(0,0,0,0); exp_q.push_back(mk(0,0,0,0,0,0)); end
                6: begin exp_q.push_back(mk(0,0,0,1,0,0)); end
                7: begin exp_q.push_back(mk(0,1,1,0,0,0)); end
                8: begin inst(0,0,0,0,0,0,0,0); wbk(1,13,1,0); exp_q.push_back(mk(0,0,1,0,0,1)); end
                9: begin wbk(0,0,0,0); drain_req = 1'b1; exp_q.push_back(mk(0,0,1,0,0,0)); end
                10: begin drain_req = 1'b0; exp_q.push_back(mk(0,0,0,0,0,0)); end
                11: begin exp_q.push_back(mk(0,0,0,1,0,0)); end
                default: begin exp_q.push_back(mk(0,0,1,0,0,0)); end
            endcase
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL drain step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_same_cycle();
        obs_t o, e;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            case (k)
                0: begin inst(1,0,0,0,0,8,1,0); wbk(0,0,0,0); exp_q.push_back(mk(0,1,1,0,0,0)); end
                1: begin wbk(1,8,1,0); exp_q.push_back(mk(0,1,1,0,0,1)); end
                2: begin inst(0,0,0,0,0,0,0,0); wbk(1,9,1,0); exp_q.push_back(mk(0,0,1,0,0,1)); end
                3: begin wbk(1,8,1,0); exp_q.push_back(mk(0,0,1,0,1,1)); end
                4: begin wbk(0,0,0,0); exp_q.push_back(mk(0,0,1,0,1,0)); end
                default: begin exp_q.push_back(mk(0,0,1,0,1,0)); end
            endcase
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL same_cycle step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        obs_t o, e;
        for (int k = 0; k < 9; k++) begin
            if (k != 5 && k != 6) @(negedge clk);
            case (k)
                0, 1, 2: begin inst(1,0,0,0,0,14 + k,1,0); wbk(0,0,0,0);
                               exp_q.push_back(mk(0,1,1,0,1,k)); end
                3: begin inst(0,0,0,0,0,0,0,0); drain_req = 1'b1; exp_q.push_back(mk(0,0,1,0,1,3)); end
                4: begin drain_req = 1'b0; inst(1,0,0,0,0,17,1,0); exp_q.push_back(mk(0,0,0,0,1,3)); end
                5: begin rst = 1'b1; exp_q.push_back(mk(0,1,1,0,0,0)); end
                6: begin exu_ready_in = 1'b0; exp_q.push_back(mk(0,1,0,0,0,0)); end
                7: begin exu_ready_in = 1'b1; rst = 1'b0; inst(0,0,0,0,0,0,0,0);
                          exp_q.push_back(mk(0,0,1,0,0,0)); end
                default: begin exp_q.push_back(mk(0,0,1,0,0,0)); end
            endcase
            #1;
            o = sample();
            e = exp_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL rst_mid_drain step %0d: got %b want %b [hz ev ir dd err infl]", k, o, e);
            end
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        exu_ready_in = 1'b1;
        drain_req    = 1'b0;
        inst(0,0,0,0,0,0,0,0);
        wbk(0,0,0,0);

        test_reset();
        test_raw();
        test_waw();
        test_x0();
        test_full();
        test_csr();
        test_drain();
        test_same_cycle();
        test_reset_mid_drain();

`ifndef YSYX_25040129_HAZARD_STAT_EN
        n_vec++;
        if (stall_cycles !== 32'd0) begin
            n_bad++;
            $display("FAIL stall_tied: got %0d want 0", stall_cycles);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
